// File: rtl/mem_adder_pkg.sv
// Shared definitions for the MemoryAdder demo: default widths and sequencer state encodings.
package mem_adder_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_ADDR_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CAP_B = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_adder_ctrl_if.sv
// Memory-side bus between the sequencer (master) and the register memory (slave).
// read_data is valid the cycle after read_en; a write commits on the edge where write_en is high.
interface mem_adder_ctrl_if #(
  parameter int WORD_SIZE = mem_adder_pkg::DEF_WORD_SIZE,
  parameter int ADDR_W    = mem_adder_pkg::DEF_ADDR_W
);
  logic                 read_en;
  logic [ADDR_W-1:0]    read_addr;
  logic [WORD_SIZE-1:0] read_data;
  logic                 write_en;
  logic [ADDR_W-1:0]    write_addr;
  logic [WORD_SIZE-1:0] write_data;

  modport master (
    output read_en, read_addr, write_en, write_addr, write_data,
    input  read_data
  );

  modport slave (
    input  read_en, read_addr, write_en, write_addr, write_data,
    output read_data
  );
endinterface

// File: rtl/mem_adder_alu.sv
// Combinational add/subtract; carry is carry-out for add and borrow (a < b) for subtract.
module mem_adder_alu #(
  parameter int WORD_SIZE = mem_adder_pkg::DEF_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 sub,
  output logic [WORD_SIZE-1:0] result,
  output logic                 carry
);
  logic [WORD_SIZE:0] sum;

  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b};
    else     sum = {1'b0, a} + {1'b0, b};
  end

  assign result = sum[WORD_SIZE-1:0];
  assign carry  = sum[WORD_SIZE];
endmodule

// File: rtl/mem_adder_ctrl.sv
// Sequencer: reads two operands from mem, adds/subtracts them, writes the result back, pulses done.
module mem_adder_ctrl
  import mem_adder_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              op_sub,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_dst,
  output logic              busy,
  output logic              done,
  output logic              carry,
  output state_t            state,
  mem_adder_ctrl_if.master  mem_bus
);

  state_t               state_q, state_d;
  logic                 sub_q;
  logic [ADDR_W-1:0]    a_q, b_q, dst_q;
  logic [WORD_SIZE-1:0] op_a, op_b;
  logic                 carry_q;
  logic [WORD_SIZE-1:0] alu_result;
  logic                 alu_carry;

  mem_adder_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .sub    (sub_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command fields are only captured on an accepted start, so a start while busy cannot disturb them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          sub_q <= op_sub;
          a_q   <= addr_a;
          b_q   <= addr_b;
          dst_q <= addr_dst;
        end
        ST_RD_B:  op_a    <= mem_bus.read_data;
        ST_CAP_B: op_b    <= mem_bus.read_data;
        ST_WR:    carry_q <= alu_carry;
        default: ;
      endcase
    end
  end

  // Mem strobes decode straight from the state register so they drop with reset.
  always_comb begin
    state_d            = state_q;
    mem_bus.read_en    = 1'b0;
    mem_bus.read_addr  = a_q;
    mem_bus.write_en   = 1'b0;
    mem_bus.write_addr = dst_q;
    mem_bus.write_data = '0;
    busy               = 1'b1;
    done               = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_RD_A;
      end
      ST_RD_A: begin
        mem_bus.read_en = 1'b1;
        state_d         = ST_RD_B;
      end
      ST_RD_B: begin
        mem_bus.read_en   = 1'b1;
        mem_bus.read_addr = b_q;
        state_d           = ST_CAP_B;
      end
      ST_CAP_B: state_d = ST_WR;
      ST_WR: begin
        mem_bus.write_en   = 1'b1;
        mem_bus.write_data = alu_result;
        state_d            = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign carry = carry_q;
  assign state = state_q;

endmodule

// File: tb/tb_mem_adder_ctrl.sv
// Bench for mem_adder_ctrl with a behavioural register memory and a write scoreboard.
module tb_mem_adder_ctrl;
  import mem_adder_pkg::*;

  localparam int W  = DEF_WORD_SIZE;
  localparam int AW = DEF_ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          start, op_sub;
  logic [AW-1:0] addr_a, addr_b, addr_dst;
  logic          busy, done, carry;
  state_t        state;

  mem_adder_ctrl_if #(.WORD_SIZE(W), .ADDR_W(AW)) bus ();

  mem_adder_ctrl #(.WORD_SIZE(W), .ADDR_W(AW)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .addr_dst (addr_dst),
    .busy     (busy),
    .done     (done),
    .carry    (carry),
    .state    (state),
    .mem_bus  (bus.master)
  );

  // behavioural 32x16 memory with a bench-side preload port
  logic [W-1:0]  mem [32];
  logic [W-1:0]  model [32];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [W-1:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.write_en) mem[bus.write_addr] <= bus.write_data;
    if (bus.read_en) bus.read_data <= mem[bus.read_addr];
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [AW+W:0] exp_q[$];
  logic [AW+W:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.write_addr), 32'(mon_e[AW+W-1:W]));
        check("wr_data", 32'(bus.write_data), 32'(mon_e[W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    model[a] = d;
  endtask

  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                        input bit sub, input bit glitch, input bit abort);
    logic [W-1:0] va, vb, r;
    int           sum;
    bit           c;
    va = model[a];
    vb = model[b];
    if (sub) begin
      r = va - vb;
      c = (va < vb);
    end else begin
      r   = va + vb;
      sum = int'(va) + int'(vb);
      c   = (sum > 65535);
    end
    @(negedge clk);
    start = 1'b1; op_sub = sub; addr_a = a; addr_b = b; addr_dst = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    op_sub   = 1'($urandom_range(0, 1));
    addr_a   = AW'($urandom_range(0, 31));
    addr_b   = AW'($urandom_range(0, 31));
    addr_dst = AW'($urandom_range(0, 31));
    if (!abort) begin
      exp_q.push_back({c, d, r});
      model[d] = r;
    end
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (glitch && cyc == 2) begin
        start = 1'b1; op_sub = 1'b1; addr_a = 5'd3; addr_b = 5'd4; addr_dst = 5'd11;
      end
      if (glitch && cyc == 3) start = 1'b0;
      if (abort) begin
        if (cyc == 2) begin
          #1 rst_n = 1'b0;
          #1;
          check("abort_we", 32'(bus.write_en), 32'd0);
          check("abort_re", 32'(bus.read_en), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_state", 32'(state), 32'(ST_IDLE));
        end else if (cyc > 2) begin
          check("abort_we_hold", 32'(bus.write_en), 32'd0);
        end
        if (cyc == 4) rst_n = 1'b1;
      end else begin
        check("we_cycle", 32'(bus.write_en), 32'(cyc == 4));
        check("done_cycle", 32'(done), 32'(cyc == 5));
        check("busy_cycle", 32'(busy), 32'(cyc <= 5));
        check("re_we_excl", 32'(bus.read_en & bus.write_en), 32'd0);
        if (cyc == 5) check("carry", 32'(carry), 32'(c));
      end
      if (cyc == 6) check("back_idle", 32'(state), 32'(ST_IDLE));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; op_sub = 1'b0;
    addr_a = '0; addr_b = '0; addr_dst = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // 1: reset with start high
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_re", 32'(bus.read_en), 32'd0);
    check("rst_we", 32'(bus.write_en), 32'd0);
    check("rst_raddr", 32'(bus.read_addr), 32'd0);
    check("rst_waddr", 32'(bus.write_addr), 32'd0);
    check("rst_wdata", 32'(bus.write_data), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(state), 32'(ST_IDLE));
    check("post_rst_busy", 32'(busy), 32'd0);

    // zero the memory so every location is defined
    for (int i = 0; i < 32; i++) preload(AW'(i), '0);

    // 2: plain add
    preload(5'd7, 16'hbeef);
    preload(5'd8, 16'h0001);
    run_op(5'd7, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0);
    check("mem9", 32'(mem[9]), 32'h0000_bef0);

    // 3: add with carry into an operand address, then subtract
    preload(5'd1, 16'hffff);
    preload(5'd2, 16'h0001);
    run_op(5'd1, 5'd2, 5'd1, 1'b0, 1'b0, 1'b0);
    check("mem1", 32'(mem[1]), 32'h0000_0000);
    run_op(5'd2, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    check("mem6", 32'(mem[6]), 32'h0000_0001);

    // 4: subtract with borrow
    preload(5'd3, 16'h0005);
    preload(5'd4, 16'h0007);
    run_op(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
    check("mem5", 32'(mem[5]), 32'h0000_fffe);

    // 5: start while busy is ignored
    preload(5'd11, 16'h1111);
    run_op(5'd7, 5'd8, 5'd10, 1'b0, 1'b1, 1'b0);
    check("mem10", 32'(mem[10]), 32'h0000_bef0);
    check("mem11_untouched", 32'(mem[11]), 32'h0000_1111);
    run_op(5'd3, 5'd4, 5'd11, 1'b0, 1'b0, 1'b0);
    check("mem11", 32'(mem[11]), 32'h0000_000c);

    // 6: reset during RD_B aborts the write
    preload(5'd12, 16'h5a5a);
    run_op(5'd3, 5'd4, 5'd12, 1'b0, 1'b0, 1'b1);
    check("mem12_kept", 32'(mem[12]), 32'h0000_5a5a);
    run_op(5'd3, 5'd4, 5'd12, 1'b0, 1'b0, 1'b0);
    check("mem12", 32'(mem[12]), 32'h0000_000c);

    // a few random operations, including same-address operands
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] ra, rb, rd;
      ra = AW'($urandom_range(13, 31));
      rb = (k == 0) ? ra : AW'($urandom_range(13, 31));
      rd = AW'($urandom_range(13, 31));
      preload(ra, W'($urandom_range(0, 65535)));
      if (rb != ra) preload(rb, W'($urandom_range(0, 65535)));
      run_op(ra, rb, rd, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check("rand_mem", 32'(mem[rd]), 32'(model[rd]));
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
